// File: rtl/serv_immdec_w.sv
// Bit-serial immediate decoder, W bits per beat.
//
// Captures instruction bits [31:7] on i_wb_en, decodes the register address
// fields and the 32-bit immediate of the selected format, then streams the
// immediate LSB-first, W bits per i_cnt_en beat (N = 32/W beats). A shadow
// copy of the immediate lets i_rewind restart the stream for two-pass ops.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wb_en          capture strobe for i_wb_rdt / i_fmt
//   i_wb_rdt[31:7]   instruction word bits 31..7
//   i_fmt            immediate format (0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR, 6/7 zero)
//   i_cnt_en         advance one beat
//   i_rewind         reload immediate from shadow, restart beat count
//   o_rd_addr, o_rs1_addr, o_rs2_addr, o_csr_imm   decoded register fields
//   o_imm            current immediate beat
//   o_cnt_done       last beat is being presented with i_cnt_en=1
//   o_valid          an instruction has been captured since reset
//   o_busy           streaming is in progress (SHIFT state)

module serv_immdec_w #(
  parameter int unsigned W = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [31:7]   i_wb_rdt,
  input  logic [2:0]    i_fmt,
  input  logic          i_cnt_en,
  input  logic          i_rewind,
  output logic [4:0]    o_rd_addr,
  output logic [4:0]    o_rs1_addr,
  output logic [4:0]    o_rs2_addr,
  output logic [4:0]    o_csr_imm,
  output logic [W-1:0]  o_imm,
  output logic          o_cnt_done,
  output logic          o_valid,
  output logic          o_busy
);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("serv_immdec_w: W must be 1, 2, 4 or 8");
  end

  localparam int unsigned N  = 32 / W;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {StEmpty, StReady, StShift, StDone} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    sreg_q;
  logic [31:0]    shadow_q;
  logic [4:0]     rd_q;
  logic [4:0]     rs1_q;
  logic [4:0]     rs2_q;
  logic           valid_q;

  logic [31:0]    imm32;
  logic           active;
  logic           last_beat;

  // Immediate decode straight from the bus; only used on capture.
  always_comb begin
    imm32 = '0;
    case (i_fmt)
      3'd0: imm32 = {{20{i_wb_rdt[31]}}, i_wb_rdt[31:20]};
      3'd1: imm32 = {{20{i_wb_rdt[31]}}, i_wb_rdt[31:25], i_wb_rdt[11:7]};
      3'd2: imm32 = {{19{i_wb_rdt[31]}}, i_wb_rdt[31], i_wb_rdt[7], i_wb_rdt[30:25],
                     i_wb_rdt[11:8], 1'b0};
      3'd3: imm32 = {i_wb_rdt[31:12], 12'b0};
      3'd4: imm32 = {{11{i_wb_rdt[31]}}, i_wb_rdt[31], i_wb_rdt[19:12], i_wb_rdt[20],
                     i_wb_rdt[30:21], 1'b0};
      3'd5: imm32 = {27'b0, i_wb_rdt[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign active    = (state_q == StReady) || (state_q == StShift);
  // Capture and rewind both override a beat advance in the same cycle.
  assign last_beat = active && i_cnt_en && !i_wb_en && !i_rewind && (cnt_q == CW'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StEmpty;
      cnt_q    <= '0;
      sreg_q   <= '0;
      shadow_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      valid_q  <= 1'b0;
    end else if (i_wb_en) begin
      rd_q     <= i_wb_rdt[11:7];
      rs1_q    <= i_wb_rdt[19:15];
      rs2_q    <= i_wb_rdt[24:20];
      sreg_q   <= imm32;
      shadow_q <= imm32;
      cnt_q    <= '0;
      valid_q  <= 1'b1;
      state_q  <= StReady;
    end else if (i_rewind && (state_q != StEmpty)) begin
      sreg_q  <= shadow_q;
      cnt_q   <= '0;
      state_q <= StReady;
    end else if (i_cnt_en && active) begin
      sreg_q <= sreg_q >> W;
      if (cnt_q == CW'(N - 1)) begin
        cnt_q   <= '0;
        state_q <= StDone;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
        state_q <= StShift;
      end
    end
  end

  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;
  assign o_csr_imm  = rs1_q;
  assign o_imm      = active ? sreg_q[W-1:0] : '0;
  assign o_cnt_done = last_beat;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q == StShift);

endmodule

// File: tb/tb_serv_immdec_w.sv
// Bench for serv_immdec_w: four instances (W = 1, 2, 4, 8) share one stimulus
// stream. The driver predicts each cycle's outputs from a beat-index model of
// the immediate and queues them; a monitor pops and compares at the falling edge.

module tb_serv_immdec_w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [31:7] rdt;
  logic [2:0]  fmt;
  logic        cnt_en;
  logic        rewind;

  always #5 clk = ~clk;

  logic [3:0][4:0] rd_o, rs1_o, rs2_o, csr_o;
  logic [3:0]      done_o, valid_o, busy_o;
  logic [0:0]      imm_w1;
  logic [1:0]      imm_w2;
  logic [3:0]      imm_w4;
  logic [7:0]      imm_w8;
  logic [3:0][7:0] imm_o;

  assign imm_o[0] = {7'b0, imm_w1};
  assign imm_o[1] = {6'b0, imm_w2};
  assign imm_o[2] = {4'b0, imm_w4};
  assign imm_o[3] = imm_w8;

  serv_immdec_w #(.W(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .i_rewind(rewind), .o_rd_addr(rd_o[0]), .o_rs1_addr(rs1_o[0]),
    .o_rs2_addr(rs2_o[0]), .o_csr_imm(csr_o[0]), .o_imm(imm_w1), .o_cnt_done(done_o[0]),
    .o_valid(valid_o[0]), .o_busy(busy_o[0]));

  serv_immdec_w #(.W(2)) u_w2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .i_rewind(rewind), .o_rd_addr(rd_o[1]), .o_rs1_addr(rs1_o[1]),
    .o_rs2_addr(rs2_o[1]), .o_csr_imm(csr_o[1]), .o_imm(imm_w2), .o_cnt_done(done_o[1]),
    .o_valid(valid_o[1]), .o_busy(busy_o[1]));

  serv_immdec_w #(.W(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .i_rewind(rewind), .o_rd_addr(rd_o[2]), .o_rs1_addr(rs1_o[2]),
    .o_rs2_addr(rs2_o[2]), .o_csr_imm(csr_o[2]), .o_imm(imm_w4), .o_cnt_done(done_o[2]),
    .o_valid(valid_o[2]), .o_busy(busy_o[2]));

  serv_immdec_w #(.W(8)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .i_rewind(rewind), .o_rd_addr(rd_o[3]), .o_rs1_addr(rs1_o[3]),
    .o_rs2_addr(rs2_o[3]), .o_csr_imm(csr_o[3]), .o_imm(imm_w8), .o_cnt_done(done_o[3]),
    .o_valid(valid_o[3]), .o_busy(busy_o[3]));

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [3:0][7:0] imm;
    logic [3:0]      done;
    logic            valid;
    logic [3:0]      busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: the captured immediate plus, per width, a phase and beat index.
  // Phase: 0 empty, 1 waiting for first beat, 2 streaming, 3 finished.
  bit [31:0] m_imm;
  bit [4:0]  m_rd, m_rs1, m_rs2;
  bit        m_valid;
  int        m_ph[4];
  int        m_k[4];

  function automatic bit [31:0] sx(int v, int bits);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 32'(v);
  endfunction

  function automatic bit [31:0] ref_imm(bit [31:7] r, bit [2:0] f);
    bit [31:0] ir;
    ir = {r, 7'b0};
    case (f)
      3'd0: return sx(int'(ir[31:20]), 12);
      3'd1: return sx(int'(ir[31:25]) * 32 + int'(ir[11:7]), 12);
      3'd2: return sx(int'(ir[31]) * 4096 + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 +
                      int'(ir[11:8]) * 2, 13);
      3'd3: return 32'(ir[31:12]) * 32'd4096;
      3'd4: return sx(int'(ir[31]) * (1 << 20) + int'(ir[19:12]) * (1 << 12) +
                      int'(ir[20]) * (1 << 11) + int'(ir[30:21]) * 2, 21);
      3'd5: return 32'(ir[19:15]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_imm = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ph[i] = 0;
      m_k[i]  = 0;
    end
  endtask

  task automatic step(bit r, bit we, bit [31:7] d, bit [2:0] f, bit ce, bit rw);
    exp_t e;
    int   w, n;
    @(posedge clk);
    #1;
    rst_n = r; wb_en = we; rdt = d; fmt = f; cnt_en = ce; rewind = rw;
    if (!r) model_reset();
    e.rd = m_rd; e.rs1 = m_rs1; e.rs2 = m_rs2; e.valid = m_valid;
    for (int i = 0; i < 4; i++) begin
      bit act;
      w = 1 << i;
      n = 32 / w;
      act = (m_ph[i] == 1) || (m_ph[i] == 2);
      e.imm[i]  = act ? 8'((m_imm >> (m_k[i] * w)) & ((32'd1 << w) - 1)) : 8'd0;
      e.done[i] = r && act && ce && !we && !rw && (m_k[i] == n - 1);
      e.busy[i] = (m_ph[i] == 2);
    end
    q.push_back(e);
    if (r) begin
      if (we) begin
        m_imm = ref_imm(d, f);
        m_rd = d[11:7]; m_rs1 = d[19:15]; m_rs2 = d[24:20]; m_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          m_ph[i] = 1;
          m_k[i]  = 0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          n = 32 >> i;
          if (rw && m_ph[i] != 0) begin
            m_ph[i] = 1;
            m_k[i]  = 0;
          end else if (ce && (m_ph[i] == 1 || m_ph[i] == 2)) begin
            if (m_k[i] == n - 1) begin
              m_ph[i] = 3;
              m_k[i]  = 0;
            end else begin
              m_ph[i] = 2;
              m_k[i]  = m_k[i] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(string name, int inst, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s W=%0d cycle=%0d got=%h want=%h", name, 1 << inst, cyc, got, want);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk("rd_addr", i, 32'(rd_o[i]), 32'(e.rd));
          chk("rs1_addr", i, 32'(rs1_o[i]), 32'(e.rs1));
          chk("rs2_addr", i, 32'(rs2_o[i]), 32'(e.rs2));
          chk("csr_imm", i, 32'(csr_o[i]), 32'(e.rs1));
          chk("imm", i, 32'(imm_o[i]), 32'(e.imm[i]));
          chk("cnt_done", i, 32'(done_o[i]), 32'(e.done[i]));
          chk("valid", i, 32'(valid_o[i]), 32'(e.valid));
          chk("busy", i, 32'(busy_o[i]), 32'(e.busy[i]));
        end
      end
    end
  end

  task automatic beats(int k);
    for (int i = 0; i < k; i++) step(1, 0, '0, 3'd0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; wb_en = 1'b0; rdt = '0; fmt = '0; cnt_en = 1'b0; rewind = 1'b0;
    model_reset();
    step(0, 0, '0, 3'd0, 0, 0);
    step(0, 0, '0, 3'd0, 1, 0);
    // Empty: advance and rewind requests do nothing.
    beats(3);
    step(1, 0, '0, 3'd0, 0, 1);

    // ADDI x1,x2,-5 (I-format).
    step(1, 1, 25'h1FF6201, 3'd0, 0, 0);
    beats(10);

    // LUI x5,0x12345 (U-format), full 32-beat stream for W=1.
    step(1, 1, 25'(32'h123452B7 >> 7), 3'd3, 0, 0);
    beats(34);

    // B-format offset -4: two beats, rewind, then restream.
    step(1, 1, 25'(32'hFE000EE3 >> 7), 3'd2, 0, 0);
    beats(2);
    step(1, 0, '0, 3'd0, 0, 1);
    beats(4);
    step(1, 0, '0, 3'd0, 1, 1);
    beats(32);
    step(1, 0, '0, 3'd0, 0, 1);
    beats(2);

    // Capture during streaming, with cnt_en also high (capture wins).
    step(1, 1, 25'(32'h8C0FF0EF >> 7), 3'd4, 0, 0);
    beats(3);
    step(1, 1, 25'(32'h3400D073 >> 7), 3'd5, 1, 0);
    beats(5);
    step(1, 1, 25'(32'hFE512E23 >> 7), 3'd1, 0, 0);
    beats(3);

    // Asynchronous reset mid-stream, then advance attempts before a new capture.
    step(0, 0, '0, 3'd0, 1, 0);
    beats(4);
    step(1, 0, '0, 3'd0, 0, 1);
    step(1, 1, 25'h1ABCDEF, 3'd6, 0, 0);
    beats(5);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, we, ce, rw;
      r  = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 11) == 0);
      ce = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 19) == 0);
      step(r, we, 25'($urandom), 3'($urandom_range(0, 7)), ce, rw);
    end
    step(1, 0, '0, 3'd0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
